// File: rtl/cpu_obi_port_arbiter.sv
// Merges the CPU instruction and data OBI master ports onto one OBI master port,
// with round-robin arbitration and in-order response routing. Optional perf counters: CPU_OBI_ARB_PERF_EN.

package cpu_obi_pkg;
   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module cpu_obi_port_arbiter
   import cpu_obi_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter bit          DATA_FIRST      = 1'b1
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  obi_req_t  instr_req_i,
   output obi_resp_t instr_resp_o,
   input  obi_req_t  data_req_i,
   output obi_resp_t data_resp_o,
   output obi_req_t  bus_req_o,
   input  obi_resp_t bus_resp_i,
   output logic [3:0] outstanding_o,
`ifdef CPU_OBI_ARB_PERF_EN
   output logic [31:0] conflict_cnt_o,
   output logic [31:0] stall_cnt_o,
`endif
   output logic      err_o
);

   localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e state_q, state_d;
   logic   owner_q, owner_d;
   logic   rr_ptr_q, rr_ptr_d;
   logic   err_q, err_d;

   // Owner FIFO: bit value 0 = instr, 1 = data
   logic [MAX_OUTSTANDING-1:0] fifo_q;
   logic [PW-1:0]              wptr_q, rptr_q;
   logic [3:0]                 count_q;

   logic     full, empty;
   logic     sel, sel_vld, push, pop, head;
   obi_req_t sel_req;

   assign full  = (count_q == 4'(MAX_OUTSTANDING));
   assign empty = (count_q == 4'd0);
   assign head  = fifo_q[rptr_q];

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      err_d        = err_q;
      sel          = 1'b0;
      sel_vld      = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      sel_req      = '0;
      bus_req_o    = '0;
      instr_resp_o = '0;
      data_resp_o  = '0;

      // Outputs are forced quiet while reset is held, even with requests present
      if (rst_ni && !full) begin
         if (state_q == LOCKED) begin
            sel     = owner_q;
            sel_vld = 1'b1;
         end else if (instr_req_i.req || data_req_i.req) begin
            sel_vld = 1'b1;
            sel     = (instr_req_i.req && data_req_i.req) ? rr_ptr_q : data_req_i.req;
         end
      end

      if (sel_vld) begin
         sel_req   = sel ? data_req_i : instr_req_i;
         bus_req_o = sel_req;
         if (sel_req.req) begin
            if (bus_resp_i.gnt) begin
               push     = 1'b1;
               rr_ptr_d = ~sel;
               state_d  = IDLE;
               if (sel) data_resp_o.gnt  = 1'b1;
               else     instr_resp_o.gnt = 1'b1;
            end else begin
               state_d = LOCKED;
               owner_d = sel;
            end
         end else begin
            // Locked owner withdrew its request: forward req=0 and release
            state_d = IDLE;
         end
      end

      if (rst_ni && bus_resp_i.rvalid) begin
         if (empty) begin
            err_d = 1'b1;
         end else begin
            pop = 1'b1;
            if (head) begin
               data_resp_o.rvalid = 1'b1;
               data_resp_o.rdata  = bus_resp_i.rdata;
            end else begin
               instr_resp_o.rvalid = 1'b1;
               instr_resp_o.rdata  = bus_resp_i.rdata;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         rr_ptr_q <= DATA_FIRST;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wptr_q] <= sel;
            wptr_q         <= (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 4'd1;
            2'b01:   count_q <= count_q - 4'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign outstanding_o = count_q;
   assign err_o         = err_q;

`ifdef CPU_OBI_ARB_PERF_EN
   logic [31:0] conflict_cnt_q, stall_cnt_q;
   logic        conflict_ev, stall_ev;

   assign conflict_ev = instr_req_i.req && data_req_i.req && push;
   assign stall_ev    = (instr_req_i.req || data_req_i.req) && full;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         conflict_cnt_q <= '0;
         stall_cnt_q    <= '0;
      end else begin
         if (conflict_ev && (conflict_cnt_q != 32'hFFFF_FFFF)) conflict_cnt_q <= conflict_cnt_q + 32'd1;
         if (stall_ev && (stall_cnt_q != 32'hFFFF_FFFF))       stall_cnt_q    <= stall_cnt_q + 32'd1;
      end
   end

   assign conflict_cnt_o = conflict_cnt_q;
   assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: doc/cpu_obi_port_arbiter.md
Name: cpu_obi_port_arbiter

Overview:
- Merges the CPU subsystem's separate instruction and data OBI master ports onto a single OBI master port.
- Sits between cpu_subsystem and the system bus, for configurations that have only one bus slot per core.
- Arbitrates requests round-robin and holds the selection stable until the bus grants it (OBI rule).
- Tracks outstanding transactions in order, so each rvalid/rdata goes back to the port that issued it.

Parameters:
- MAX_OUTSTANDING, 2: depth of the in-order owner-tracking FIFO. Legal range 1..8.
- DATA_FIRST, 1: reset value of the round-robin pointer. 1 = data wins the first conflict; 0 = instr wins.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  obi_req_t  CPU instruction request (req, addr, we, be, wdata)
- instr_resp_o  out  obi_resp_t  instruction gnt, rvalid, rdata
- data_req_i  in  obi_req_t  CPU data request
- data_resp_o  out  obi_resp_t  data gnt, rvalid, rdata
- bus_req_o  out  obi_req_t  merged request to the bus
- bus_resp_i  in  obi_resp_t  bus gnt, rvalid, rdata
- outstanding_o  out  4  number of entries in the tracking FIFO
- err_o  out  1  sticky flag: orphan rvalid seen

Behaviour:
- Reset: FIFO empty, outstanding_o=0, err_o=0, state=IDLE, rr_ptr=DATA_FIRST. All bus_req_o and *_resp_o fields are 0.
- Full condition: FIFO is full when count == MAX_OUTSTANDING.
  - When full: bus_req_o.req=0 and no gnt is returned to either port.
  - A pop in the same cycle does not unmask the request; the request is unmasked from the next cycle.
- State machine IDLE / LOCKED:
  - IDLE, not full:
    - Only one requester active: that requester is selected.
    - Both active: the one indicated by rr_ptr is selected.
    - The selected requester's fields drive bus_req_o combinationally.
    - If bus_resp_i.gnt=1 in the same cycle: push the owner (0=instr, 1=data), assert gnt to the owner only (0-cycle grant path), toggle rr_ptr away from the owner, stay in IDLE.
    - If gnt=0: register the owner and go to LOCKED.
  - LOCKED:
    - bus_req_o is driven from the locked owner's port regardless of the other port.
    - On gnt: push, grant the owner, update rr_ptr, return to IDLE.
    - A locked owner dropping req before gnt violates OBI. The block simply forwards req=0 and returns to IDLE (no error flag).
- Unselected port: gnt=0. Its request is held pending.
- Response routing:
  - bus_resp_i.rvalid is routed to the FIFO head owner: that port gets rvalid=1 and rdata=bus rdata. The other port gets rvalid=0 and rdata=0.
  - The FIFO entry is popped on the same edge.
  - rvalid with the FIFO empty: dropped, err_o set (sticky until reset).
- Simultaneous gnt and rvalid (FIFO not full): push and pop on the same edge; count unchanged.
- The bus response is one cycle or more after gnt, so the push always precedes the matching pop. The FIFO is strictly in-order.
- Reset asserted mid-transaction: all state clears asynchronously. In-flight responses after reset release are orphan rvalids and set err_o.
- Latency: zero added cycles on both the request path and the response path. The only registered elements are the lock owner, rr_ptr, the FIFO and err_o.

Optional Feature:
- Macro: CPU_OBI_ARB_PERF_EN.
- When defined, adds two outputs: conflict_cnt_o (32) and stall_cnt_o (32).
  - conflict_cnt_o increments each cycle both ports request and a gnt occurs.
  - stall_cnt_o increments each cycle any port requests while the FIFO is full.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- When not defined, neither the ports nor the counters exist.

Test Plan:
- Instr only: instr req addr 0x180, bus gnt the same cycle, rvalid 1 cycle later with rdata 0xDEADBEEF → instr_resp_o gnt in cycle 0 and rvalid in cycle 1 with 0xDEADBEEF; data_resp_o stays all-zero; outstanding_o goes 1 then 0.
- Conflict with DATA_FIRST=1: both ports request every cycle, gnt always 1 → grants alternate data, instr, data, instr; bus_req_o.addr alternates accordingly.
- Lock: data requests with gnt held 0 for 3 cycles while instr rises in cycle 1 → bus_req_o.addr stays the data address for all 3 cycles; instr is granted the cycle after data's gnt.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid → bus_req_o.req=0 and outstanding_o=2. After one rvalid, req reasserts in the next cycle.
- Ordering: issue instr then data, return two rvalids with 0x1 then 0x2 → instr receives 0x1, data receives 0x2.
- Orphan and reset: rvalid with the FIFO empty → err_o=1 and no port rvalid. Assert rst_ni low mid-lock → all outputs return to 0 immediately.
